// File: rtl/alu_exec.sv
// -----------------------------------------------------------------------------
// alu_exec
//
// Sequencer that hands one operation at a time to an external combinational
// ALU. A request is latched in IDLE. The ALU is enabled for one EXEC cycle, and
// its result and flags are captured on the EXEC->DONE edge. A one-cycle done
// pulse then marks completion. At most one operation is accepted every three
// cycles.
//
// Ports
//   clk         rising-edge clock for all state
//   reset       synchronous active-high reset
//   start       request one operation (sampled only in IDLE)
//   opcode_in   operation code, latched on accept
//   op_a/op_b   operands, latched on accept
//   use_carry   1 = feed stored C flag to the ALU carry-in, latched on accept
//   alu_out     result returned by the ALU
//   alu_flags   flags returned by the ALU, {P,S,Z,O,C}
//   alu_oe      ALU output enable (EXEC only)
//   alu_opcode  latched opcode to the ALU
//   alu_in1/2   latched operands to the ALU
//   alu_carry   ALU carry-in
//   busy        high in EXEC and DONE
//   done        one-cycle completion pulse
//   result      last captured ALU result
//   flags       last captured ALU flags
// -----------------------------------------------------------------------------
module alu_exec #(
  parameter int width       = 16,
  parameter int flags_width = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [3:0]             opcode_in,
  input  logic [width-1:0]       op_a,
  input  logic [width-1:0]       op_b,
  input  logic                   use_carry,
  input  logic [width-1:0]       alu_out,
  input  logic [flags_width-1:0] alu_flags,
  output logic                   alu_oe,
  output logic [3:0]             alu_opcode,
  output logic [width-1:0]       alu_in1,
  output logic [width-1:0]       alu_in2,
  output logic                   alu_carry,
  output logic                   busy,
  output logic                   done,
  output logic [width-1:0]       result,
  output logic [flags_width-1:0] flags
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [3:0]       opcode_q;
  logic [width-1:0] a_q;
  logic [width-1:0] b_q;
  logic             carry_q;

  // NOTE: every register below uses non-blocking assignment, so all state
  // updates see the pre-edge values and simulate the way the flops behave.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      opcode_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      result   <= '0;
      flags    <= '0;
      alu_oe   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            opcode_q <= opcode_in;
            a_q      <= op_a;
            b_q      <= op_b;
            carry_q  <= use_carry;
            state    <= EXEC;
            alu_oe   <= 1'b1;
            busy     <= 1'b1;
          end
        end
        EXEC: begin
          // The only edge at which the ALU response is observed.
          result <= alu_out;
          flags  <= alu_flags;
          state  <= DONE;
          alu_oe <= 1'b0;
          done   <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          alu_oe <= 1'b0;
          busy   <= 1'b0;
          done   <= 1'b0;
        end
      endcase
    end
  end

  assign alu_opcode = opcode_q;
  assign alu_in1    = a_q;
  assign alu_in2    = b_q;
  // The carry-in uses the stored C flag. During EXEC this is the flag from the
  // previous operation, because the new flags land only on the EXEC->DONE edge.
  assign alu_carry  = carry_q & flags[0];

endmodule

// File: tb/tb_alu_exec.sv
// -----------------------------------------------------------------------------
// tb_alu_exec
//
// Self-checking bench for alu_exec. The bench acts as the external ALU by
// driving alu_out/alu_flags. The expected behaviour is tracked at the
// transaction level: the last captured result and flags, and the carry-in that
// should be offered to the ALU.
// -----------------------------------------------------------------------------
module tb_alu_exec;
  localparam int W  = 16;
  localparam int FW = 5;

  logic          clk;
  logic          reset;
  logic          start;
  logic [3:0]    opcode_in;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          use_carry;
  logic [W-1:0]  alu_out;
  logic [FW-1:0] alu_flags;
  logic          alu_oe;
  logic [3:0]    alu_opcode;
  logic [W-1:0]  alu_in1;
  logic [W-1:0]  alu_in2;
  logic          alu_carry;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic [FW-1:0] flags;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Transaction-level model: what the block should currently be holding.
  logic [W-1:0]  exp_result = '0;
  logic [FW-1:0] exp_flags  = '0;

  alu_exec #(.width(W), .flags_width(FW)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode_in(opcode_in),
    .op_a(op_a), .op_b(op_b), .use_carry(use_carry), .alu_out(alu_out),
    .alu_flags(alu_flags), .alu_oe(alu_oe), .alu_opcode(alu_opcode),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_carry(alu_carry),
    .busy(busy), .done(done), .result(result), .flags(flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Advance one edge, then settle, so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one full operation starting from IDLE and checks every cycle of it.
  // Returns in IDLE, one step after the DONE->IDLE edge.
  task automatic run_op(input logic [3:0] opc, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic uc,
                        input logic [W-1:0] aout, input logic [FW-1:0] afl);
    logic exp_c;
    // Junk ALU values in IDLE must have no effect on the capture.
    alu_out   = ~aout;
    alu_flags = ~afl;
    start = 1'b1; opcode_in = opc; op_a = a; op_b = b; use_carry = uc;
    tick();
    // EXEC
    exp_c = uc & exp_flags[0];
    checks++; if (alu_oe !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL exec_ctrl oe/busy/done got %b%b%b want 110", alu_oe, busy, done); end
    checks++; if (alu_opcode !== opc || alu_in1 !== a || alu_in2 !== b) begin
      errors++; $display("FAIL exec_latch got %h/%h/%h want %h/%h/%h", alu_opcode, alu_in1, alu_in2, opc, a, b); end
    checks++; if (alu_carry !== exp_c) begin
      errors++; $display("FAIL exec_carry got %b want %b", alu_carry, exp_c); end
    start = 1'b0;
    op_a = ~a; op_b = ~b; opcode_in = ~opc; use_carry = ~uc;
    alu_out = aout; alu_flags = afl;
    tick();
    // DONE
    exp_result = aout;
    exp_flags  = afl;
    alu_out = W'($urandom); alu_flags = FW'($urandom);
    checks++; if (done !== 1'b1 || alu_oe !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL done_ctrl done/oe/busy got %b%b%b want 101", done, alu_oe, busy); end
    checks++; if (result !== exp_result || flags !== exp_flags) begin
      errors++; $display("FAIL capture got %h/%b want %h/%b", result, flags, exp_result, exp_flags); end
    checks++; if (alu_in1 !== a || alu_in2 !== b || alu_opcode !== opc) begin
      errors++; $display("FAIL done_latch got %h/%h/%h want %h/%h/%h", alu_in1, alu_in2, alu_opcode, a, b, opc); end
    checks++; if (alu_carry !== (uc & exp_flags[0])) begin
      errors++; $display("FAIL done_carry got %b want %b", alu_carry, uc & exp_flags[0]); end
    tick();
    // IDLE
    checks++; if (done !== 1'b0 || busy !== 1'b0 || alu_oe !== 1'b0) begin
      errors++; $display("FAIL idle_ctrl done/busy/oe got %b%b%b want 000", done, busy, alu_oe); end
    checks++; if (result !== exp_result || flags !== exp_flags) begin
      errors++; $display("FAIL idle_hold got %h/%b want %h/%b", result, flags, exp_result, exp_flags); end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_result = '0;
    exp_flags  = '0;
  endtask

  task automatic test_reset();
    // Reset wins even with start asserted.
    start = 1'b1; op_a = 16'h1111; op_b = 16'h2222; opcode_in = 4'hF; use_carry = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    checks++; if ({alu_oe, busy, done, alu_carry} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl got %b want 0000", {alu_oe, busy, done, alu_carry}); end
    checks++; if (alu_opcode !== 4'h0 || alu_in1 !== '0 || alu_in2 !== '0) begin
      errors++; $display("FAIL reset_latch got %h/%h/%h want 0/0/0", alu_opcode, alu_in1, alu_in2); end
    checks++; if (result !== '0 || flags !== '0) begin
      errors++; $display("FAIL reset_out got %h/%b want 0/0", result, flags); end
    start = 1'b0;
    reset = 1'b0;
    exp_result = '0;
    exp_flags  = '0;
    tick();
    checks++; if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle busy got %b want 0", busy); end
  endtask

  task automatic test_basic();
    run_op(4'h2, 16'h0005, 16'h0003, 1'b0, 16'h0008, 5'b00000);
  endtask

  task automatic test_carry_chain();
    run_op(4'h1, 16'h8000, 16'h8000, 1'b0, 16'h0000, 5'b00001);
    run_op(4'h1, 16'h0001, 16'h0001, 1'b1, 16'h0003, 5'b00001); // alu_carry 1
    run_op(4'h1, 16'h0002, 16'h0002, 1'b0, 16'h0004, 5'b00000); // alu_carry 0
  endtask

  task automatic test_busy_reject();
    int dones;
    int first_cycle;
    int acc2_ok;
    dones = 0;
    acc2_ok = 0;
    alu_out = 16'h0101; alu_flags = 5'b00000;
    start = 1'b1; op_a = 16'hAAAA; op_b = 16'h0F0F; opcode_in = 4'h3; use_carry = 1'b0;
    first_cycle = cycle;
    tick();
    op_a = 16'h5555;
    for (int i = 0; i < 6; i++) begin
      if (done === 1'b1) dones++;
      if (i == 0 || i == 1) begin
        checks++; if (alu_in1 !== 16'hAAAA) begin
          errors++; $display("FAIL busy_hold step %0d alu_in1 got %h want aaaa", i, alu_in1); end
      end
      if (i == 3 && alu_in1 === 16'h5555 && alu_oe === 1'b1) acc2_ok = 1;
      if (i == 3) start = 1'b0;
      tick();
    end
    checks++; if (acc2_ok !== 1) begin
      errors++; $display("FAIL busy_reaccept got %0d want 1", acc2_ok); end
    checks++; if (dones !== 2 || cycle - first_cycle !== 7) begin
      errors++; $display("FAIL busy_two_ops done pulses got %0d want 2 (cycles %0d)", dones, cycle - first_cycle); end
    exp_result = 16'h0101;
    exp_flags  = 5'b00000;
    checks++; if (result !== exp_result || busy !== 1'b0) begin
      errors++; $display("FAIL busy_end got %h/%b want 0101/0", result, busy); end
  endtask

  task automatic test_reset_mid();
    // Reset during EXEC.
    start = 1'b1; op_a = 16'h1357; op_b = 16'h2468; opcode_in = 4'h5; use_carry = 1'b1;
    tick();
    start = 1'b0;
    alu_out = 16'hFFFF; alu_flags = 5'b11111;
    do_reset();
    checks++; if (done !== 1'b0 || alu_oe !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_exec done/oe/busy got %b%b%b want 000", done, alu_oe, busy); end
    checks++; if (result !== '0 || flags !== '0 || alu_in1 !== '0) begin
      errors++; $display("FAIL rst_exec_regs got %h/%b/%h want 0/0/0", result, flags, alu_in1); end
    tick();
    checks++; if (done !== 1'b0 || result !== '0) begin
      errors++; $display("FAIL rst_exec_after got %b/%h want 0/0", done, result); end
    // Reset while in DONE removes the pulse.
    run_op(4'h7, 16'h0F00, 16'h00F0, 1'b0, 16'h0FF0, 5'b00100);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    do_reset();
    checks++; if (done !== 1'b0 || busy !== 1'b0 || result !== '0 || flags !== '0) begin
      errors++; $display("FAIL rst_done got %b/%b/%h/%b want 0/0/0/0", done, busy, result, flags); end
  endtask

  task automatic test_hold();
    run_op(4'h4, 16'h1000, 16'h0234, 1'b0, 16'h1234, 5'b10100);
    alu_out = 16'hDEAD; alu_flags = 5'b01011; start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (result !== 16'h1234 || flags !== 5'b10100 || busy !== 1'b0) begin
        errors++; $display("FAIL hold cycle %0d got %h/%b/%b want 1234/10100/0", i, result, flags, busy); end
    end
  endtask

  task automatic test_width();
    run_op(4'hF, 16'hFFFF, 16'h8000, 1'b1, 16'h7FFF, 5'b11111);
  endtask

  task automatic test_back_to_back();
    int c0;
    c0 = cycle;
    for (int i = 0; i < 3; i++)
      run_op(4'(i), 16'(i * 3), 16'(i + 9), 1'b1, 16'(i * 7 + 1), 5'(i));
    checks++; if (cycle - c0 !== 9) begin
      errors++; $display("FAIL b2b_rate cycles got %0d want 9", cycle - c0); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      run_op(4'($urandom_range(0, 15)), W'($urandom), W'($urandom),
             1'($urandom_range(0, 1)), W'($urandom), FW'($urandom));
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; opcode_in = '0; op_a = '0; op_b = '0;
    use_carry = 1'b0; alu_out = '0; alu_flags = '0;
    #2;
    test_reset();
    test_basic();
    test_carry_chain();
    test_busy_reject();
    test_reset_mid();
    test_hold();
    test_width();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit in case anything stalls.
  initial begin
    #200000;
    $display("FAIL timeout after %0d cycles", cycle);
    $fatal(1, "timeout");
  end
endmodule
